control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: INPUT_W, default 8, input element width; WEIGHT_W, default 8, weight element width; DATA_W, default 32, memory word width; ARRAY_SIZE (N), default 4, systolic array dimension.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nRST  in  1  synchronous active-high reset; nRST=1 resets on the next rising edge.
REQ-005 mem_data  in  DATA_W  read data; valid the cycle after mem_rd_en.
REQ-006 mem_addr  out  32  word address: zero-extended base plus index.
REQ-007 mem_rd_en  out  1  read request.
REQ-008 mem_wr_en  out  1  write request.
REQ-009 op0_precision, op1_precision  in  3 each  operand precision codes.
REQ-010 input_precision, output_precision  out  3 each  latched precision codes.
REQ-011 input_base_addr, weight_base_addr, output_base_addr  in  10 each  word base addresses.
REQ-012 compute_en  out  1  array MAC enable.
REQ-013 input_forward  out  N x INPUT_W  per-row data into the array; row r is word lane r, bits [r*8+7:r*8].

Function
REQ-014 State sequence: IDLE(1) -> LOAD_W(N) -> LOAD_I(N) -> STREAM(2N-1) -> DRAIN(N) -> WRITE(N) -> DONE. The sequence starts automatically after reset.
REQ-015 A counter i runs from 0 to len-1 in each multi-cycle state and clears on every state change.
REQ-016 IDLE: input_precision <= op0_precision and output_precision <= op1_precision; both hold until the next reset.
REQ-017 LOAD_W: mem_rd_en=1 and mem_addr=weight_base_addr+i.
REQ-018 Weight word j, returned one cycle after its request, is registered onto input_forward unskewed (lane r -> row r) with compute_en=0.
REQ-019 LOAD_I: mem_rd_en=1 and mem_addr=input_base_addr+i.
REQ-020 Returned word j is stored in input buffer buf[j]; the last word is captured during STREAM cycle 0.
REQ-021 STREAM cycle k (0..2N-2) registers input_forward[r] <= lane r of buf[k-r] when 0<=k-r<N, else 0.
REQ-022 STREAM also registers compute_en <= 1, so outputs lag the state by 1 cycle.
REQ-023 DRAIN: input_forward <= 0 and compute_en <= 1.
REQ-024 WRITE: compute_en <= 0, mem_wr_en=1 and mem_addr=output_base_addr+i; write data comes from outside this block.
REQ-025 DONE: mem_rd_en=mem_wr_en=compute_en=0, input_forward=0, mem_addr=0; the block stays in DONE until reset.
REQ-026 mem_rd_en and mem_wr_en are never both 1.
REQ-027 Outside LOAD_W, LOAD_I and WRITE: mem_rd_en=0, mem_wr_en=0 and mem_addr=0.
REQ-028 Address arithmetic is 32-bit and never wraps inside the 10-bit base range plus N.
REQ-029 Base and precision inputs are sampled when their state is active; changes at other times are ignored.

Reset
REQ-030 Under reset, every output is 0 on the next edge: mem_addr, mem_rd_en, mem_wr_en, compute_en, input_forward, input_precision, output_precision.
REQ-031 Under reset, state goes to IDLE, the counter clears and the buffer clears.
REQ-032 Reset asserted mid-operation aborts the sequence; it restarts from IDLE on the first edge after release.

Structure
REQ-033 Shared package holds the state enum (IDLE, LOAD_W, LOAD_I, STREAM, DRAIN, WRITE, DONE) and the default parameter constants.
REQ-034 One sub-module, input_skew_buffer, holds buf and produces the diagonal skew; the FSM, counter and memory interface stay in control_unit.

Verification
REQ-035 Reset held 2 cycles, released -> all outputs 0 during reset; first edge after release is in IDLE; then mem_rd_en=1 with mem_addr=0..3 over 4 cycles.
REQ-036 op0=4, op1=4, all bases 0, mem_data=0xAAAAAAAA -> input_precision=4 and output_precision=4; weight words appear as four rows of 0xAA with compute_en=0.
REQ-037 Same setup, STREAM -> input_forward row pattern follows the diagonal {AA,0,0,0},{AA,AA,0,0},...,{0,0,0,AA} over 7 cycles with compute_en=1, then 4 DRAIN cycles of 0.
REQ-038 output_base_addr=0x3F0 -> WRITE drives mem_wr_en=1 with mem_addr 0x3F0..0x3F3, then DONE with all outputs 0.
REQ-039 Reset asserted during STREAM -> outputs 0 next edge; full sequence repeats from IDLE after release.
REQ-040 Every cycle: assert not(mem_rd_en and mem_wr_en); assert compute_en=0 whenever mem_wr_en=1.

Source files
------------

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared state encoding, default sizes and per-state lengths for the control unit.
package control_unit_pkg;
    localparam int INPUT_W_DEF    = 8;
    localparam int WEIGHT_W_DEF   = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int ARRAY_SIZE_DEF = 4;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, STREAM, DRAIN, WRITE, DONE} state_e;

    function automatic int last_idx(state_e s, int n);
        return (s inside {LOAD_W, LOAD_I, DRAIN, WRITE}) ? n - 1 : (s == STREAM) ? 2 * n - 2 : 0;
    endfunction
endpackage

// File: rtl/input_skew_buffer.sv
// input_skew_buffer: holds the loaded input words and presents them diagonally skewed across rows.
module input_skew_buffer
    import control_unit_pkg::*;
#(
    parameter int INPUT_W    = INPUT_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    localparam int IW = $clog2(ARRAY_SIZE),
    localparam int CW = $clog2(2 * ARRAY_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [IW-1:0]                 wr_idx_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic [CW-1:0]                 k_i,
    output logic [ARRAY_SIZE*INPUT_W-1:0] skew_o
);
    logic [DATA_W-1:0] buf_q [ARRAY_SIZE];

    always_ff @(posedge clk) begin
        if (rst) buf_q <= '{default: '0};
        else if (wr_en_i) buf_q[wr_idx_i] <= wr_data_i;
    end

    // Row r at step k sees word k-r, so each row starts one cycle after the row above it.
    always_comb begin
        skew_o = '0;
        for (int r = 0; r < ARRAY_SIZE; r++)
            if (int'(k_i) >= r && int'(k_i) - r < ARRAY_SIZE)
                skew_o[r*INPUT_W +: INPUT_W] = buf_q[IW'(int'(k_i) - r)][r*INPUT_W +: INPUT_W];
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: sequences weight/input loads, skewed streaming, drain and write-back for a systolic array.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int INPUT_W    = INPUT_W_DEF,
    parameter int WEIGHT_W   = WEIGHT_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic [DATA_W-1:0]             mem_data,
    output logic [31:0]                   mem_addr,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    input  logic [2:0]                    op0_precision,
    input  logic [2:0]                    op1_precision,
    output logic [2:0]                    input_precision,
    output logic [2:0]                    output_precision,
    input  logic [9:0]                    input_base_addr,
    input  logic [9:0]                    weight_base_addr,
    input  logic [9:0]                    output_base_addr,
    output logic                          compute_en,
    output logic [ARRAY_SIZE*INPUT_W-1:0] input_forward
);
    localparam int CW = $clog2(2 * ARRAY_SIZE);
    localparam int IW = $clog2(ARRAY_SIZE);
    localparam int FW = ARRAY_SIZE * INPUT_W;

    state_e          state_q, state_d;
    logic [CW-1:0]   i_q, i_d;
    logic [IW-1:0]   idx_q;
    logic            wval_q, ival_q, ce_q, last;
    logic [FW-1:0]   fwd_q, fwd_d, skew, w_row;
    logic [2:0]      inp_q, outp_q;
    logic [9:0]      base;

    input_skew_buffer #(.INPUT_W(INPUT_W), .DATA_W(DATA_W), .ARRAY_SIZE(ARRAY_SIZE)) u_skew (
        .clk       (clk),
        .rst       (nRST),
        .wr_en_i   (ival_q),
        .wr_idx_i  (idx_q),
        .wr_data_i (mem_data),
        .k_i       (i_q),
        .skew_o    (skew)
    );

    always_comb begin
        last = int'(i_q) == last_idx(state_q, ARRAY_SIZE);
        state_d = (state_q == DONE) ? DONE : last ? state_e'(state_q + 3'd1) : state_q;
        i_d = (last || state_q == DONE) ? '0 : i_q + 1'b1;
        base = (state_q == LOAD_W) ? weight_base_addr : (state_q == LOAD_I) ? input_base_addr : output_base_addr;
        mem_rd_en = state_q inside {LOAD_W, LOAD_I};
        mem_wr_en = state_q == WRITE;
        mem_addr = (mem_rd_en || mem_wr_en) ? {22'd0, base} + 32'(i_q) : '0;
        w_row = '0;
        for (int r = 0; r < ARRAY_SIZE; r++)
            w_row[r*INPUT_W +: INPUT_W] = mem_data[r*WEIGHT_W +: INPUT_W];
        fwd_d = wval_q ? w_row : (state_q == STREAM) ? skew : (state_q inside {DRAIN, WRITE, DONE}) ? '0 : fwd_q;
    end

    // Read data trails its request by one cycle, so the load strobes and index are delayed to match.
    always_ff @(posedge clk) begin
        if (nRST) begin
            state_q <= IDLE;
            i_q     <= '0;
            idx_q   <= '0;
            wval_q  <= 1'b0;
            ival_q  <= 1'b0;
            ce_q    <= 1'b0;
            fwd_q   <= '0;
            inp_q   <= '0;
            outp_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            idx_q   <= i_q[IW-1:0];
            wval_q  <= state_q == LOAD_W;
            ival_q  <= state_q == LOAD_I;
            ce_q    <= state_q inside {STREAM, DRAIN};
            fwd_q   <= fwd_d;
            if (state_q == IDLE) begin
                inp_q  <= op0_precision;
                outp_q <= op1_precision;
            end
        end
    end

    // The array must be quiet while results are written out, even on the last drain beat.
    assign compute_en       = ce_q & ~mem_wr_en;
    assign input_forward    = fwd_q;
    assign input_precision  = inp_q;
    assign output_precision = outp_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, table-driven check of the control unit sequence, skew, write-back and reset abort.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] mem_data = '0;
    logic [31:0] mem_addr;
    logic        mem_rd_en, mem_wr_en, compute_en;
    logic [2:0]  op0_precision, op1_precision, input_precision, output_precision;
    logic [9:0]  input_base_addr, weight_base_addr, output_base_addr;
    logic [31:0] input_forward;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pat   = 0;

    typedef struct {
        logic        rd, wr, ce;
        logic [31:0] addr, fwd;
    } vec_t;
    vec_t tbl [26];

    always #5 clk = ~clk;

    control_unit dut (
        .clk              (clk),
        .nRST             (nRST),
        .mem_data         (mem_data),
        .mem_addr         (mem_addr),
        .mem_rd_en        (mem_rd_en),
        .mem_wr_en        (mem_wr_en),
        .op0_precision    (op0_precision),
        .op1_precision    (op1_precision),
        .input_precision  (input_precision),
        .output_precision (output_precision),
        .input_base_addr  (input_base_addr),
        .weight_base_addr (weight_base_addr),
        .output_base_addr (output_base_addr),
        .compute_en       (compute_en),
        .input_forward    (input_forward)
    );

    function automatic logic [31:0] word(logic [31:0] a);
        logic [7:0] b = a[7:0];
        return (pat == 0) ? 32'hAAAA_AAAA : {b + 8'h30, b + 8'h20, b + 8'h10, b};
    endfunction

    always @(posedge clk) mem_data <= mem_rd_en ? word(mem_addr) : '0;

    always @(negedge clk) begin
        tests++;
        if ((mem_rd_en && mem_wr_en) || (mem_wr_en && compute_en)) begin
            fails++;
            $display("FAIL protocol cyc=%0d rd=%b wr=%b ce=%b required no rd&wr and no wr&ce", cyc, mem_rd_en, mem_wr_en, compute_en);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) step();
    endtask

    task automatic chk_quiet(string name);
        chk({name, ".rd"}, 32'(mem_rd_en), 0);
        chk({name, ".wr"}, 32'(mem_wr_en), 0);
        chk({name, ".ce"}, 32'(compute_en), 0);
        chk({name, ".addr"}, mem_addr, 0);
        chk({name, ".fwd"}, input_forward, 0);
    endtask

    task automatic chk_prec(string name, logic [2:0] ip, logic [2:0] op);
        chk({name, ".in_prec"}, 32'(input_precision), 32'(ip));
        chk({name, ".out_prec"}, 32'(output_precision), 32'(op));
    endtask

    function automatic vec_t mk(logic rd, logic wr, logic ce, logic [31:0] addr, logic [31:0] fwd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ce = ce; v.addr = addr; v.fwd = fwd;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(0, 0, 0, 32'h000, 32'h0000_0000);
        tbl[1]  = mk(1, 0, 0, 32'h000, 32'h0000_0000);
        tbl[2]  = mk(1, 0, 0, 32'h001, 32'h0000_0000);
        tbl[3]  = mk(1, 0, 0, 32'h002, 32'hAAAA_AAAA);
        tbl[4]  = mk(1, 0, 0, 32'h003, 32'hAAAA_AAAA);
        tbl[5]  = mk(1, 0, 0, 32'h000, 32'hAAAA_AAAA);
        tbl[6]  = mk(1, 0, 0, 32'h001, 32'hAAAA_AAAA);
        tbl[7]  = mk(1, 0, 0, 32'h002, 32'hAAAA_AAAA);
        tbl[8]  = mk(1, 0, 0, 32'h003, 32'hAAAA_AAAA);
        tbl[9]  = mk(0, 0, 0, 32'h000, 32'hAAAA_AAAA);
        tbl[10] = mk(0, 0, 1, 32'h000, 32'h0000_00AA);
        tbl[11] = mk(0, 0, 1, 32'h000, 32'h0000_AAAA);
        tbl[12] = mk(0, 0, 1, 32'h000, 32'h00AA_AAAA);
        tbl[13] = mk(0, 0, 1, 32'h000, 32'hAAAA_AAAA);
        tbl[14] = mk(0, 0, 1, 32'h000, 32'hAAAA_AA00);
        tbl[15] = mk(0, 0, 1, 32'h000, 32'hAAAA_0000);
        tbl[16] = mk(0, 0, 1, 32'h000, 32'hAA00_0000);
        tbl[17] = mk(0, 0, 1, 32'h000, 32'h0000_0000);
        tbl[18] = mk(0, 0, 1, 32'h000, 32'h0000_0000);
        tbl[19] = mk(0, 0, 1, 32'h000, 32'h0000_0000);
        tbl[20] = mk(0, 1, 0, 32'h3F0, 32'h0000_0000);
        tbl[21] = mk(0, 1, 0, 32'h3F1, 32'h0000_0000);
        tbl[22] = mk(0, 1, 0, 32'h3F2, 32'h0000_0000);
        tbl[23] = mk(0, 1, 0, 32'h3F3, 32'h0000_0000);
        tbl[24] = mk(0, 0, 0, 32'h000, 32'h0000_0000);
        tbl[25] = mk(0, 0, 0, 32'h000, 32'h0000_0000);

        nRST = 1'b1;
        op0_precision = 3'd4; op1_precision = 3'd4;
        input_base_addr = '0; weight_base_addr = '0; output_base_addr = 10'h3F0;
        @(negedge clk);
        step();
        chk_quiet("rst_a");
        step();
        chk_quiet("rst_b");
        chk_prec("rst_b", 3'd0, 3'd0);
        nRST = 1'b0;
        cyc = 0;
        for (int c = 0; c < 26; c++) begin
            if (c > 0) step();
            if (c == 2) begin op0_precision = 3'd7; op1_precision = 3'd1; end
            chk("run1.rd", 32'(mem_rd_en), 32'(tbl[c].rd));
            chk("run1.wr", 32'(mem_wr_en), 32'(tbl[c].wr));
            chk("run1.ce", 32'(compute_en), 32'(tbl[c].ce));
            chk("run1.addr", mem_addr, tbl[c].addr);
            chk("run1.fwd", input_forward, tbl[c].fwd);
        end
        chk_prec("run1_done", 3'd4, 3'd4);

        nRST = 1'b1;
        step();
        chk_quiet("rst_from_done");
        chk_prec("rst_from_done", 3'd0, 3'd0);
        op0_precision = 3'd2; op1_precision = 3'd5;
        weight_base_addr = 10'h010; input_base_addr = 10'h040; output_base_addr = 10'h3FF;
        pat = 1;
        nRST = 1'b0;
        cyc = 0;
        run_to(1);
        chk("run2.rd", 32'(mem_rd_en), 1);
        chk("run2.waddr0", mem_addr, 32'h10);
        chk_prec("run2", 3'd2, 3'd5);
        run_to(3);  chk("run2.wrow0", input_forward, 32'h4030_2010);
        run_to(4);  chk("run2.waddr3", mem_addr, 32'h13);
        run_to(5);  chk("run2.iaddr0", mem_addr, 32'h40);
        run_to(6);  chk("run2.wrow3", input_forward, 32'h4333_2313);
        run_to(8);  chk("run2.iaddr3", mem_addr, 32'h43);
        run_to(12);
        chk("run2.k2", input_forward, 32'h0060_5142);
        chk("run2.ce", 32'(compute_en), 1);
        run_to(13); chk("run2.k3", input_forward, 32'h7061_5243);

        nRST = 1'b1;
        step();
        chk_quiet("rst_mid_stream");
        chk_prec("rst_mid_stream", 3'd0, 3'd0);
        op0_precision = 3'd1; op1_precision = 3'd6;
        nRST = 1'b0;
        cyc = 0;
        run_to(1);
        chk("run3.rd", 32'(mem_rd_en), 1);
        chk("run3.waddr0", mem_addr, 32'h10);
        chk_prec("run3", 3'd1, 3'd6);
        run_to(14); chk("run3.k4", input_forward, 32'h7162_5300);
        run_to(15); chk("run3.k5", input_forward, 32'h7263_0000);
        run_to(17);
        chk("run3.drain_fwd", input_forward, 0);
        chk("run3.drain_ce", 32'(compute_en), 1);
        run_to(20);
        chk("run3.wr", 32'(mem_wr_en), 1);
        chk("run3.oaddr0", mem_addr, 32'h3FF);
        chk("run3.wr_ce", 32'(compute_en), 0);
        run_to(23); chk("run3.oaddr3", mem_addr, 32'h402);
        run_to(24);
        chk_quiet("run3_done");
        chk_prec("run3_done", 3'd1, 3'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
